// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder with a 32 x 8-bit register file.
// Ports:
//   Clk, Reset_n             system clock, synchronous active-low reset
//   spi_ss_n/sclk/mosi       SPI slave inputs (asynchronous to Clk)
//   spi_miso, spi_miso_oe    SPI slave output and its drive enable
//   irq                      registered |(reg25 & reg26)
//   loc_we/addr/wdata        fabric-side register write port
//   loc_raddr, loc_rdata     fabric-side combinational register read
//   loc_collide              pulse when a local write loses to an SPI commit
//   busy                     transaction in progress
module spi_reg_responder #(
  parameter logic [7:0] REV_VALUE = 8'h13
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       irq,
  input  logic       loc_we,
  input  logic [4:0] loc_addr,
  input  logic [7:0] loc_wdata,
  input  logic [4:0] loc_raddr,
  output logic [7:0] loc_rdata,
  output logic       loc_collide,
  output logic       busy
);

  localparam logic [4:0] ADDR_REV    = 5'd18;
  localparam logic [4:0] ADDR_STATUS = 5'd25;
  localparam logic [4:0] ADDR_MASK   = 5'd26;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t     state_q;
  logic [7:0] regs [32];

  logic ss_meta, ss_sync, ss_prev;
  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;
  logic       miso_q;
  logic       oe_q;
  logic [4:0] addr_q;
  logic       wr_dir;
  logic       load_pending;

  logic       ss_fall, sclk_rise, sclk_fall;
  logic       spi_we;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;
  logic       loc_drop;

  // Synchronizers run free of reset so that, after a reset, a select that is
  // already low is not mistaken for a fresh SS_n falling edge.
  always_ff @(posedge Clk) begin
    ss_meta   <= spi_ss_n;
    ss_sync   <= ss_meta;
    ss_prev   <= ss_sync;
    sclk_meta <= spi_sclk;
    sclk_sync <= sclk_meta;
    sclk_prev <= sclk_sync;
    mosi_meta <= spi_mosi;
    mosi_sync <= mosi_meta;
  end

  assign ss_fall   = ss_prev & ~ss_sync;
  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;

  assign spi_wdata = {rx_sr, mosi_sync};
  assign spi_we    = (state_q == DATA) && !ss_sync && sclk_rise &&
                     (bit_cnt == 3'd7) && wr_dir;
  assign loc_drop  = loc_we && spi_we && (loc_addr == addr_q);

  assign loc_rdata = (loc_raddr == ADDR_REV) ? REV_VALUE : regs[loc_raddr];
  assign spi_rdata = (addr_q == ADDR_REV) ? REV_VALUE : regs[addr_q];

  assign spi_miso    = oe_q ? miso_q : 1'b1;
  assign spi_miso_oe = oe_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      miso_q       <= 1'b1;
      oe_q         <= 1'b0;
      addr_q       <= '0;
      wr_dir       <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      oe_q <= ~ss_sync;
      if (ss_sync) begin
        state_q      <= IDLE;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        miso_q       <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_fall) begin
              state_q      <= CMD;
              bit_cnt      <= '0;
              load_pending <= 1'b0;
              miso_q       <= regs[ADDR_STATUS][7];
              tx_sr        <= regs[ADDR_STATUS][6:0];
            end
          end
          CMD, DATA: begin
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[5:0], mosi_sync};
              // 3-bit counter wraps to zero on each byte boundary
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                load_pending <= 1'b1;
                if (state_q == CMD) begin
                  state_q <= DATA;
                  addr_q  <= rx_sr[6:2];
                  wr_dir  <= rx_sr[0];
                end
              end
            end
            if (sclk_fall) begin
              // first falling edge after a byte boundary starts the next byte
              if (load_pending) begin
                load_pending <= 1'b0;
                miso_q       <= spi_rdata[7];
                tx_sr        <= spi_rdata[6:0];
              end else begin
                miso_q <= tx_sr[6];
                tx_sr  <= {tx_sr[5:0], 1'b0};
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // SPI commit is written after the local write so it wins on a same-address hit.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      regs        <= '{default: '0};
      irq         <= 1'b0;
      loc_collide <= 1'b0;
    end else begin
      if (loc_we && !loc_drop && (loc_addr != ADDR_REV)) begin
        if (loc_addr == ADDR_STATUS)
          regs[ADDR_STATUS] <= regs[ADDR_STATUS] | loc_wdata;
        else
          regs[loc_addr] <= loc_wdata;
      end
      if (spi_we && (addr_q != ADDR_REV)) begin
        if (addr_q == ADDR_STATUS)
          regs[ADDR_STATUS] <= regs[ADDR_STATUS] & ~spi_wdata;
        else
          regs[addr_q] <= spi_wdata;
      end
      loc_collide <= loc_drop;
      irq         <= |(regs[ADDR_STATUS] & regs[ADDR_MASK]);
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: SPI mode-0 master model with
// a queue of expected MISO bytes and register values.
module tb_spi_reg_responder;

  localparam int HALF = 6;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, irq, loc_collide, busy;
  logic       loc_we = 1'b0;
  logic [4:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic [4:0] loc_raddr = '0;
  logic [7:0] loc_rdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       coll_p3, coll_p4;
  logic [7:0] snap;

  spi_reg_responder #(.REV_VALUE(8'h13)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_raddr(loc_raddr), .loc_rdata(loc_rdata),
    .loc_collide(loc_collide), .busy(busy)
  );

  always #10 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge Clk); loc_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [7:0] d);
    @(negedge Clk); loc_raddr = a;
    #1 d = loc_rdata;
  endtask

  // Shifts n bits; optionally fires a local write in the commit cycle of bit 8.
  // snap holds loc_rdata 3 Clk after the last raw rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit coll,
                          input logic [4:0] ca, input logic [7:0] cd,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge Clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      @(posedge Clk); @(posedge Clk); @(negedge Clk);
      if (coll && i == 7) begin
        loc_we = 1'b1; loc_addr = ca; loc_wdata = cd;
      end
      @(posedge Clk); #1 coll_p3 = loc_collide; snap = loc_rdata;
      @(negedge Clk); loc_we = 1'b0;
      @(posedge Clk); #1 coll_p4 = loc_collide;
      repeat (3) @(negedge Clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, 1'b0, 5'd0, 8'h00, rx);
  endtask

  task automatic spi_start();
    @(negedge Clk); spi_ss_n = 1'b0;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic spi_stop();
    repeat (HALF) @(negedge Clk); spi_ss_n = 1'b1;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge Clk);
    checks++; if ({spi_miso, spi_miso_oe, irq, loc_collide, busy} !== 5'b10000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", {spi_miso, spi_miso_oe, irq, loc_collide, busy}, 5'b10000); end
    exp_q.push_back(8'h00); exp_q.push_back(8'h13); exp_q.push_back(8'h00);
    rd_reg(5'd25, d);
    checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL reset_reg25 got=%h exp=%h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_reg(5'd18, d);
    checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL reset_reg18 got=%h exp=%h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_reg(5'd20, d);
    checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL reset_reg20 got=%h exp=%h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge Clk); Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_read_rev();
    logic [7:0] rx, e;
    exp_q.push_back(8'h00); exp_q.push_back(8'h13);
    spi_start();
    spi_byte(8'h90, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL rev_status got=%h exp=%h", rx, e); end
    spi_byte(8'h00, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL rev_data got=%h exp=%h", rx, e); end
    spi_stop();
  endtask

  task automatic test_write();
    logic [7:0] rx, e;
    loc_raddr = 5'd20;
    exp_q.push_back(8'h00); exp_q.push_back(8'h5C);
    spi_start();
    spi_byte(8'hA2, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL wr_status got=%h exp=%h", rx, e); end
    spi_byte(8'h5C, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL wr_commit got=%h exp=%h", snap, e); end
    repeat (HALF) @(negedge Clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_hi got=%b exp=1", busy); end
    spi_ss_n = 1'b1;
    @(posedge Clk); @(posedge Clk); @(posedge Clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_drop got=%b exp=0", busy); end
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic test_status_irq();
    logic [7:0] rx, e, d;
    loc_write(5'd26, 8'h01);
    loc_write(5'd25, 8'h01);
    @(negedge Clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    loc_raddr = 5'd25;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    spi_start();
    spi_byte(8'hCA, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL st_cmd_miso got=%h exp=%h", rx, e); end
    spi_byte(8'h01, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL st_w1c got=%h exp=%h", snap, e); end
    spi_stop();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    // local writes OR into status, SPI clears only the ones written
    loc_write(5'd25, 8'h81);
    loc_write(5'd25, 8'h02);
    exp_q.push_back(8'h83);
    rd_reg(5'd25, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL st_loc_or got=%h exp=%h", d, e); end
    exp_q.push_back(8'h83); exp_q.push_back(8'h01);
    spi_start();
    spi_byte(8'hCA, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL st_cmd_miso2 got=%h exp=%h", rx, e); end
    spi_byte(8'h82, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL st_w1c_part got=%h exp=%h", snap, e); end
    spi_stop();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_remain got=%b exp=1", irq); end
    // revision register ignores local and SPI writes
    loc_write(5'd18, 8'hAA);
    loc_raddr = 5'd18;
    exp_q.push_back(8'h13);
    spi_start();
    spi_byte(8'h92, rx);
    spi_byte(8'h55, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL rev_readonly got=%h exp=%h", snap, e); end
    spi_stop();
  endtask

  task automatic test_collision();
    logic [7:0] rx, e, d;
    loc_write(5'd20, 8'h11);
    loc_raddr = 5'd20;
    exp_q.push_back(8'h01); exp_q.push_back(8'h5C);
    spi_start();
    spi_byte(8'hA2, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL col_status got=%h exp=%h", rx, e); end
    spi_bits(8'h5C, 8, 1'b1, 5'd20, 8'hFF, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL col_spi_wins got=%h exp=%h", snap, e); end
    checks++; if ({coll_p3, coll_p4} !== 2'b10) begin failures++; $display("FAIL col_pulse got=%b exp=10", {coll_p3, coll_p4}); end
    spi_stop();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h5C);
    spi_start();
    spi_byte(8'hA2, rx);
    spi_bits(8'h5C, 8, 1'b1, 5'd21, 8'hFF, rx);
    checks++; if ({coll_p3, coll_p4} !== 2'b00) begin failures++; $display("FAIL col_nopulse got=%b exp=00", {coll_p3, coll_p4}); end
    spi_stop();
    rd_reg(5'd21, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL col_reg21 got=%h exp=%h", d, e); end
    rd_reg(5'd20, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL col_reg20 got=%h exp=%h", d, e); end
  endtask

  task automatic test_abort();
    logic [7:0] rx, e, d;
    exp_q.push_back(8'h5C);
    spi_start();
    spi_byte(8'hA2, rx);
    spi_bits(8'h33, 4, 1'b0, 5'd0, 8'h00, rx);
    spi_stop();
    rd_reg(5'd20, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL abort_nochange got=%h exp=%h", d, e); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
    loc_raddr = 5'd20;
    exp_q.push_back(8'h77);
    spi_start();
    spi_byte(8'hA2, rx);
    spi_byte(8'h77, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL abort_next got=%h exp=%h", snap, e); end
    spi_stop();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx, e;
    exp_q.push_back(8'h01);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h77);
    spi_start();
    spi_byte(8'hA0, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL b2b_status got=%h exp=%h", rx, e); end
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx); e = exp_q.pop_front();
      checks++; if (rx !== e) begin failures++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, rx, e); end
    end
    spi_stop();
    loc_raddr = 5'd20;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    spi_start();
    spi_byte(8'hA2, rx);
    spi_byte(8'h12, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL b2b_wr0 got=%h exp=%h", snap, e); end
    spi_byte(8'h34, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL b2b_wr1 got=%h exp=%h", snap, e); end
    spi_stop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, e, d;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rm_pre_irq got=%b exp=1", irq); end
    spi_start();
    spi_byte(8'hA2, rx);
    spi_bits(8'hC3, 3, 1'b0, 5'd0, 8'h00, rx);
    @(negedge Clk); Reset_n = 1'b0;
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    checks++; if ({spi_miso, spi_miso_oe, irq, loc_collide, busy} !== 5'b10000) begin
      failures++; $display("FAIL rm_outputs got=%b exp=%b", {spi_miso, spi_miso_oe, irq, loc_collide, busy}, 5'b10000); end
    Reset_n = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd_reg(5'd25, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rm_reg25 got=%h exp=%h", d, e); end
    // SCLK activity with select still low must be ignored
    spi_bits(8'h18, 5, 1'b0, 5'd0, 8'h00, rx);
    spi_byte(8'hA2, rx);
    spi_byte(8'h99, rx);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_ignore_busy got=%b exp=0", busy); end
    spi_stop();
    rd_reg(5'd20, d); e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rm_nocommit got=%h exp=%h", d, e); end
    loc_raddr = 5'd20;
    exp_q.push_back(8'h3C);
    spi_start();
    spi_byte(8'hA2, rx);
    spi_byte(8'h3C, rx); e = exp_q.pop_front();
    checks++; if (snap !== e) begin failures++; $display("FAIL rm_after_wr got=%h exp=%h", snap, e); end
    spi_stop();
    exp_q.push_back(8'h00); exp_q.push_back(8'h3C);
    spi_start();
    spi_byte(8'hA0, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL rm_rd_status got=%h exp=%h", rx, e); end
    spi_byte(8'h00, rx); e = exp_q.pop_front();
    checks++; if (rx !== e) begin failures++; $display("FAIL rm_rd_data got=%h exp=%h", rx, e); end
    spi_stop();
  endtask

  initial begin
    test_reset();
    test_read_rev();
    test_write();
    test_status_irq();
    test_collision();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 Parameter REV_VALUE, default 8'h13: fixed read-only value of register 18 (REVISION).
REQ-002 Clk  input  1  single system clock (50 MHz); all logic is on rising edge.
REQ-003 Reset_n  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-004 spi_ss_n  input  1  SPI slave select from master, active low, asynchronous to Clk.
REQ-005 spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to Clk.
REQ-006 spi_mosi  input  1  master-out data, MSB first.
REQ-007 spi_miso  output  1  slave-out data, MSB first.
REQ-008 spi_miso_oe  output  1  MISO drive enable; high only while selected.
REQ-009 irq  output  1  interrupt: high when (reg25 & reg26) != 0.
REQ-010 loc_we, loc_addr[4:0], loc_wdata[7:0]  input  fabric-side register write port.
REQ-011 loc_raddr[4:0] input, loc_rdata[7:0] output  fabric-side combinational read of the register file.
REQ-012 loc_collide  output  1  one-cycle pulse when a local write is dropped.
REQ-013 busy  output  1  high while a transaction is in progress (state != IDLE).

Function
REQ-014 Register file: 32 x 8-bit registers; reg18 reads REV_VALUE and ignores all writes.
REQ-015 spi_ss_n, spi_sclk and spi_mosi each pass through a 2-FF synchronizer; edges are detected on the synchronized SCLK.
REQ-016 The master SHALL hold the SCLK high and low phases for at least 4 Clk each; the block is not required to work with faster SCLK.
REQ-017 FSM states: IDLE, CMD, DATA.
- IDLE->CMD on synchronized SS_n falling edge.
- CMD->DATA after the 8th SCLK rising edge.
- DATA stays in DATA across bytes.
- Any state->IDLE on synchronized SS_n high.
REQ-018 A 3-bit bit counter clears on entry to CMD and on each byte boundary; MOSI is sampled on synchronized SCLK rising edges.
REQ-019 Command byte layout:
- bits[7:3] address.
- bit1 direction (1 = write, 0 = read).
- bits 2 and 0 are ignored.
REQ-020 While the command byte shifts in, MISO shifts out reg25 (status), loaded on SS_n falling-edge detection.
REQ-021 All data bytes in one transaction access the same latched address; there is no auto-increment.
REQ-022 Read data byte: the shift register loads reg[addr] at the SCLK falling edge following the previous byte's 8th rising edge; MISO updates on every synchronized SCLK falling edge.
REQ-023 Write data byte: on the 8th rising edge the byte commits to reg[addr] within 3 Clk of the raw SCLK edge.
REQ-024 SPI write to reg25 is write-1-to-clear (reg25 <= reg25 & ~data); all other SPI writes replace the register value.
REQ-025 Local write to reg25 ORs in (reg25 <= reg25 | data); all other local writes replace the register value.
REQ-026 Local write and SPI commit in the same Clk cycle:
- Same address: SPI wins, the local write is dropped, and loc_collide pulses for 1 cycle.
- Different addresses: both writes complete.
REQ-027 If SS_n rises mid-byte, the partial byte is discarded with no register change and the FSM returns to IDLE.
REQ-028 spi_miso_oe = !synchronized SS_n; while spi_miso_oe is low, spi_miso = 1.
REQ-029 irq is registered and updates 1 Clk after any change of reg25 or reg26.

Reset
REQ-030 While Reset_n is low at a rising Clk edge, the block SHALL enter IDLE on the following cycle and hold:
- all registers at 8'h00 except reg18;
- bit counter = 0, spi_miso = 1, spi_miso_oe = 0;
- irq = 0, loc_collide = 0, busy = 0.
REQ-031 Reset asserted mid-transaction aborts the transaction with no commit; after reset release, the block ignores SCLK until the next SS_n falling edge.

Verification
REQ-032 SPI write: cmd 8'hA2 (reg20, write) then 8'h5C -> reg20 == 8'h5C within 3 Clk of the 16th rising edge; busy drops within 3 Clk of SS_n rising.
REQ-033 Read after reset: cmd 8'h90 (reg18, read) then a dummy byte -> MISO bits 0x00 (status) then 0x13.
REQ-034 Status/IRQ:
- Local write reg26=8'h01, then local write reg25=8'h01 -> irq = 1.
- SPI write cmd 8'hCA, data 8'h01 -> reg25 = 0x00 and irq = 0.
- During the command byte, MISO returned 0x01.
REQ-035 Collision: local write reg20=8'hFF in the same Clk as the SPI commit of 8'h5C to reg20 -> reg20 = 8'h5C and loc_collide pulses 1 cycle; repeat with loc_addr=21 -> reg21 = 8'hFF and no pulse.
REQ-036 Abort: SS_n raised after 4 data bits of a write to reg20 -> reg20 unchanged; next full transaction works normally.
REQ-037 Reset mid-transaction: Reset_n low for 2 Clk during a data byte -> all outputs at reset values and no commit; a following transaction completes correctly.
